// File: rtl/row_sequencer.sv
// row_sequencer: issues operand beats to a 3-MAC row element and sums its results into one row dot-product
// Ports: clk/rst (async, active-low); in_* operand beat valid/ready input; row_* start/operands/results/done
// toward the row element; out_* valid/ready row total and beat count; err sticky flag, err_clr clears it.
// Build option: define SEQ_SATURATE_EN to saturate the accumulator instead of wrapping modulo 2^ACCW.
module row_sequencer #(
  parameter int DW      = 16,
  parameter int ACCW    = 40,
  parameter int CNTW    = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [DW-1:0]     in_x0,
  input  logic [DW-1:0]     in_x1,
  input  logic [DW-1:0]     in_x2,
  input  logic [DW-1:0]     in_w0,
  input  logic [DW-1:0]     in_w1,
  input  logic [DW-1:0]     in_w2,
  output logic              row_start,
  output logic [DW-1:0]     row_x0,
  output logic [DW-1:0]     row_x1,
  output logic [DW-1:0]     row_x2,
  output logic [DW-1:0]     row_w0,
  output logic [DW-1:0]     row_w1,
  output logic [DW-1:0]     row_w2,
  output logic [2*DW-1:0]   row_acc_in,
  input  logic [2*DW-1:0]   row_acc0,
  input  logic [2*DW-1:0]   row_acc1,
  input  logic [2*DW-1:0]   row_acc2,
  input  logic              row_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACCW-1:0]   out_sum,
  output logic [CNTW-1:0]   out_beats,
  output logic              err,
  input  logic              err_clr
);
  localparam int TW = $clog2(TIMEOUT + 1);
`ifdef SEQ_SATURATE_EN
  localparam int XW = ACCW + 2;
`else
  localparam int XW = ACCW;
`endif
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUTPUT, ERROR} state_t;
  state_t          state;
  logic [ACCW-1:0] sum;
  logic [CNTW-1:0] count;
  logic            armed;
  logic            last_q;
  logic [TW-1:0]   timer;
  logic [XW-1:0]   nxt;
  logic [ACCW-1:0] sum_nxt;
  logic [CNTW-1:0] cnt_nxt;
  logic            ovf;
  assign nxt = XW'($signed(sum)) + XW'($signed(row_acc0)) + XW'($signed(row_acc1)) + XW'($signed(row_acc2));
`ifdef SEQ_SATURATE_EN
  // the top three bits agree only when the true total still fits in ACCW signed bits
  assign sum_nxt = (nxt[XW-1:ACCW-1] == '0 || nxt[XW-1:ACCW-1] == '1) ? nxt[ACCW-1:0]
                                                                         : {nxt[XW-1], {(ACCW-1){~nxt[XW-1]}}};
`else
  assign sum_nxt = nxt;
`endif
  assign cnt_nxt    = count + 1'b1;
  // a row that would fill the counter is closed early and flagged
  assign ovf        = (&cnt_nxt) && !last_q;
  assign row_acc_in = '0;
  assign out_sum    = sum;
  assign out_beats  = count;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sum       <= '0;
      count     <= '0;
      armed     <= 1'b0;
      last_q    <= 1'b0;
      timer     <= '0;
      in_ready  <= 1'b0;
      row_start <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      row_x0    <= '0;
      row_x1    <= '0;
      row_x2    <= '0;
      row_w0    <= '0;
      row_w1    <= '0;
      row_w2    <= '0;
    end else begin
      row_start <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            row_x0    <= in_x0;
            row_x1    <= in_x1;
            row_x2    <= in_x2;
            row_w0    <= in_w0;
            row_w1    <= in_w1;
            row_w2    <= in_w2;
            last_q    <= in_last;
            in_ready  <= 1'b0;
            row_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // a done already high at start is stale and must be seen low before it counts
          armed <= ~row_done;
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (armed && row_done) begin
            sum   <= sum_nxt;
            count <= cnt_nxt;
            if (last_q || ovf) begin
              out_valid <= 1'b1;
              state     <= OUTPUT;
              if (ovf) err <= 1'b1;
            end else begin
              in_ready <= 1'b1;
              state    <= IDLE;
            end
          end else begin
            if (!row_done) armed <= 1'b1;
            timer <= timer + 1'b1;
            if (timer == TW'(TIMEOUT - 1)) begin
              err   <= 1'b1;
              state <= ERROR;
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            sum       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        ERROR: begin
          if (err_clr) begin
            err      <= 1'b0;
            sum      <= '0;
            count    <= '0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_row_sequencer.sv
// tb_row_sequencer: directed vectors for row_sequencer, default build plus a narrow ACCW=34/CNTW=2 copy
module tb_row_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, in_last = 1'b0, row_done = 1'b0, out_ready = 1'b0, err_clr = 1'b0;
  logic signed [15:0] in_x0 = '0, in_x1 = '0, in_x2 = '0, in_w0 = '0, in_w1 = '0, in_w2 = '0;
  logic signed [31:0] row_acc0 = '0, row_acc1 = '0, row_acc2 = '0;
  logic in_ready, row_start, out_valid, err;
  logic [15:0] row_x0, row_x1, row_x2, row_w0, row_w1, row_w2;
  logic [31:0] row_acc_in;
  logic signed [39:0] out_sum;
  logic [7:0] out_beats;
  logic in_ready2, row_start2, out_valid2, err2;
  logic [15:0] r2x0, r2x1, r2x2, r2w0, r2w1, r2w2;
  logic [31:0] row_acc_in2;
  logic signed [33:0] out_sum2;
  logic [1:0] out_beats2;
`ifdef SEQ_SATURATE_EN
  localparam logic signed [63:0] WRAP_EXP = 64'sd8589934591;
`else
  localparam logic signed [63:0] WRAP_EXP = -64'sd7516192768;
`endif
  row_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_x0(in_x0), .in_x1(in_x1), .in_x2(in_x2), .in_w0(in_w0), .in_w1(in_w1), .in_w2(in_w2),
    .row_start(row_start), .row_x0(row_x0), .row_x1(row_x1), .row_x2(row_x2),
    .row_w0(row_w0), .row_w1(row_w1), .row_w2(row_w2), .row_acc_in(row_acc_in),
    .row_acc0(row_acc0), .row_acc1(row_acc1), .row_acc2(row_acc2), .row_done(row_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_beats(out_beats),
    .err(err), .err_clr(err_clr)
  );
  row_sequencer #(.DW(16), .ACCW(34), .CNTW(2), .TIMEOUT(64)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_last(in_last),
    .in_x0(in_x0), .in_x1(in_x1), .in_x2(in_x2), .in_w0(in_w0), .in_w1(in_w1), .in_w2(in_w2),
    .row_start(row_start2), .row_x0(r2x0), .row_x1(r2x1), .row_x2(r2x2),
    .row_w0(r2w0), .row_w1(r2w1), .row_w2(r2w2), .row_acc_in(row_acc_in2),
    .row_acc0(row_acc0), .row_acc1(row_acc1), .row_acc2(row_acc2), .row_done(row_done),
    .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2), .out_beats(out_beats2),
    .err(err2), .err_clr(err_clr)
  );
  int nv = 0, nf = 0, starts = 0;
  always @(negedge clk) if (row_start) starts <= starts + 1;
  typedef struct {
    logic signed [15:0] x0, x1, x2, w0, w1, w2;
    int lat;
    logic signed [63:0] sum;
  } vec_t;
  vec_t vecs[6];
  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    nv++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic accept(input logic signed [15:0] x0, x1, x2, w0, w1, w2, input logic last);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    in_x0 = x0; in_x1 = x1; in_x2 = x2;
    in_w0 = w0; in_w1 = w1; in_w2 = w2;
    in_last = last;
    row_acc0 = x0 * w0;
    row_acc1 = x1 * w1;
    row_acc2 = x2 * w2;
    @(negedge clk);
    in_valid = 1'b0;
    chk("issue_ready_low", in_ready, 0);
    chk("issue_start", row_start, 1);
  endtask
  task automatic done_after(input int lat);
    repeat (lat) @(negedge clk);
    chk("wait_ready_low", in_ready, 0);
    chk("wait_start_low", row_start, 0);
    row_done = 1'b1;
    @(negedge clk);
    row_done = 1'b0;
  endtask
  task automatic wait_out(input string nm);
    int t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_valid"}, out_valid, 1);
  endtask
  task automatic get_out(input string nm, input logic signed [63:0] es, input int eb);
    wait_out(nm);
    chk({nm, "_sum"}, out_sum, es);
    chk({nm, "_beats"}, out_beats, eb);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_valid_drop"}, out_valid, 0);
  endtask
  initial begin
    int s0, n;
    logic signed [63:0] held;
    vecs[0] = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 2, 64'sd32};
    vecs[1] = '{-16'sd1, -16'sd1, -16'sd1, 16'sd100, 16'sd100, 16'sd100, 1, -64'sd300};
    vecs[2] = '{16'sd0, 16'sd0, 16'sd0, 16'sd5, 16'sd6, 16'sd7, 3, 64'sd0};
    vecs[3] = '{16'sd32767, -16'sd32768, 16'sd7, 16'sd2, 16'sd1, -16'sd3, 1, 64'sd32745};
    vecs[4] = '{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 2, 64'sd3221225472};
    vecs[5] = '{16'sd10, -16'sd20, 16'sd30, -16'sd3, 16'sd4, 16'sd5, 4, 64'sd40};
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_row_start", row_start, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_sum", out_sum, 0);
    chk("idle_beats", out_beats, 0);
    for (int i = 0; i < 6; i++) begin
      s0 = starts;
      accept(vecs[i].x0, vecs[i].x1, vecs[i].x2, vecs[i].w0, vecs[i].w1, vecs[i].w2, 1'b1);
      done_after(vecs[i].lat);
      get_out($sformatf("vec%0d", i), vecs[i].sum, 1);
      chk($sformatf("vec%0d_starts", i), starts - s0, 1);
    end
    for (int b = 0; b < 3; b++) begin
      accept(-16'sd1, -16'sd1, -16'sd1, 16'sd100, 16'sd100, 16'sd100, b == 2);
      done_after(2);
      if (b < 2) chk("multi_ready_after_capture", in_ready, 1);
    end
    get_out("multi", -64'sd900, 3);
    row_done = 1'b1;
    @(negedge clk);
    accept(16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 1'b1);
    @(negedge clk);
    chk("stale_done_ignored", out_valid, 0);
    row_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("stale_no_capture", out_valid, 0);
    row_done = 1'b1;
    @(negedge clk);
    row_done = 1'b0;
    get_out("stale", 64'sd32, 1);
    accept(16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 1'b0);
    done_after(1);
    accept(16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7, 1'b1);
    n = 0;
    while (!err && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, 65);
    chk("error_in_ready", in_ready, 0);
    chk("error_out_valid", out_valid, 0);
    repeat (3) @(negedge clk);
    chk("error_sticky", err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_err", err, 0);
    chk("clr_in_ready", in_ready, 1);
    chk("clr_sum", out_sum, 0);
    accept(16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 1'b1);
    done_after(2);
    get_out("after_clr", 64'sd32, 1);
    accept(16'sd5, 16'sd0, 16'sd0, 16'sd5, 16'sd0, 16'sd0, 1'b1);
    done_after(1);
    wait_out("bp");
    held = out_sum;
    chk("bp_sum", held, 25);
    in_valid = 1'b1;
    in_x0 = 16'sd1; in_x1 = 16'sd1; in_x2 = 16'sd1;
    in_w0 = 16'sd1; in_w1 = 16'sd1; in_w2 = 16'sd1;
    in_last = 1'b1;
    row_acc0 = 32'sd1; row_acc1 = 32'sd1; row_acc2 = 32'sd1;
    s0 = starts;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", c), out_valid, 1);
      chk($sformatf("bp_hold_sum%0d", c), out_sum, 25);
      chk($sformatf("bp_hold_ready%0d", c), in_ready, 0);
    end
    chk("bp_no_start", starts - s0, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_resume_start", row_start, 1);
    done_after(1);
    get_out("bp_next", 64'sd3, 1);
    for (int b = 0; b < 3; b++) begin
      accept(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, b == 2);
      done_after(1);
    end
    wait_out("wide");
    chk("wide_sum", out_sum, 64'sd9663676416);
    chk("wrap_valid", out_valid2, 1);
    chk("wrap_sum", out_sum2, WRAP_EXP);
    chk("wrap_beats", out_beats2, 3);
    chk("wrap_err", err2, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      accept(16'sd1, 16'sd0, 16'sd0, 16'sd1, 16'sd0, 16'sd0, 1'b0);
      done_after(1);
    end
    chk("ovf_valid", out_valid2, 1);
    chk("ovf_beats", out_beats2, 3);
    chk("ovf_sum", out_sum2, 3);
    chk("ovf_err", err2, 1);
    chk("ovf_wide_idle", out_valid, 0);
    chk("ovf_wide_err", err, 0);
    accept(16'sd2, 16'sd2, 16'sd2, 16'sd2, 16'sd2, 16'sd2, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_row_x0", row_x0, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_row_start", row_start, 0);
    chk("arst_sum", out_sum, 0);
    chk("arst_valid2", out_valid2, 0);
    chk("arst_err2", err2, 0);
    chk("arst_sum2", out_sum2, 0);
    chk("arst_beats2", out_beats2, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end
endmodule
